// File: rtl/regfile_dump.sv
// regfile_dump: walks a register-file read port over an address window
// and streams each captured word out as an address/data pair.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    FIN
  } state_t;

  localparam logic [ADDR_W-1:0] MAX_REG =
    ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_d;
  logic [ADDR_W-1:0] lim;
  logic [ADDR_W-1:0] lim_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              vld_q;
  logic              vld_d;
  logic [ADDR_W-1:0] last_cl;

  // Keep the limit inside the register file when the
  // address space is wider than the file itself.
  if (NUM_REGS < (2 ** ADDR_W)) begin : g_clamp
    assign last_cl = (last_reg > MAX_REG) ?
                     MAX_REG : last_reg;
  end else begin : g_direct
    assign last_cl = last_reg;
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    lim_d   = lim;
    addr_d  = addr_q;
    data_d  = data_q;
    vld_d   = vld_q;
    if (abort) begin
      state_d = IDLE;
      vld_d   = 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            cnt_d = first_reg;
            lim_d = last_cl;
            if (first_reg > last_cl) begin
              state_d = FIN;
            end else begin
              state_d = READ;
            end
          end
        end
        (state == READ): begin
          data_d  = rd_data;
          addr_d  = cnt;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
        (state == HOLD): begin
          // Last word stops without bumping the counter.
          if (out_ready) begin
            vld_d = 1'b0;
            if (cnt == lim) begin
              state_d = FIN;
            end else begin
              cnt_d   = cnt + 1'b1;
              state_d = READ;
            end
          end
        end
        (state == FIN): begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      lim    <= '0;
      addr_q <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      lim    <= lim_d;
      addr_q <= addr_d;
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign rd_addr   = cnt;
  assign out_valid = vld_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: vector table plus hand sequences, scoreboard of
// expected words popped on every accepting edge.
module tb_regfile_dump;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] f;
    logic [AW-1:0] l;
    int            rmode;
    int            exp_done;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] first_reg = '0;
  logic [AW-1:0] last_reg = '0;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] rf [32];
  assign rd_data = rf[rd_addr];

  always #5 clk = ~clk;

  regfile_dump #(
    .NUM_REGS(32),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .first_reg(first_reg),
    .last_reg (last_reg),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  int            n_chk = 0;
  int            n_fail = 0;
  int            t;
  int            done_cnt;
  int            done_t;
  int            fv_t;
  bit            vseen;
  bit            busy_done;
  bit            held_v;
  logic [AW-1:0] held_a;
  logic [DW-1:0] held_d;
  bit            pw_en = 1'b0;
  int            pw_t;
  logic [AW-1:0] pw_a;
  logic [DW-1:0] pw_d;
  wd_t           q[$];
  vec_t          vt[6];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_rd_addr"}, 64'(rd_addr), 0);
    chk({nm, "_valid"}, 64'(out_valid), 0);
    chk({nm, "_addr"}, 64'(out_addr), 0);
    chk({nm, "_data"}, 64'(out_data), 0);
    chk({nm, "_busy"}, 64'(busy), 0);
    chk({nm, "_done"}, 64'(done), 0);
  endtask

  task automatic push_window(input int f, input int l);
    for (int a = f; a <= l; a++) begin
      q.push_back('{a: AW'(a), d: rf[a]});
    end
  endtask

  task automatic step(input logic s,
                      input logic a,
                      input int rmode);
    wd_t e;
    @(negedge clk);
    if (pw_en && (t + 1 == pw_t)) begin
      rf[pw_a] = pw_d;
      pw_en = 1'b0;
    end
    start = s;
    abort = a;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    #1;
    t++;
    if (done) begin
      done_cnt++;
      done_t = t;
      busy_done = busy;
    end
    if (out_valid && !vseen) begin
      vseen = 1'b1;
      fv_t = t;
    end
    if (held_v) begin
      chk("hold_valid", 64'(out_valid), 1);
      chk("hold_addr", 64'(out_addr), 64'(held_a));
      chk("hold_data", 64'(out_data), 64'(held_d));
    end
    if (out_valid && out_ready && !abort) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_word: got addr %0d data %0h expected none",
                 out_addr, out_data);
      end else begin
        e = q.pop_front();
        chk("word_addr", 64'(out_addr), 64'(e.a));
        chk("word_data", 64'(out_data), 64'(e.d));
      end
    end
    held_v = out_valid && !out_ready && !abort;
    held_a = out_addr;
    held_d = out_data;
  endtask

  task automatic start_dump(input int f,
                            input int l,
                            input int rmode);
    first_reg = AW'(f);
    last_reg = AW'(l);
    done_cnt = 0;
    done_t = -1;
    fv_t = -1;
    vseen = 1'b0;
    busy_done = 1'b0;
    held_v = 1'b0;
    t = -1;
    step(1'b1, 1'b0, rmode);
  endtask

  task automatic finish_dump(input int rmode,
                             input int exp_done,
                             input bit exp_v,
                             input int exp_rd);
    for (int k = 0; k < 600 && done_cnt == 0; k++) begin
      if (rmode == 1) begin
        first_reg = AW'($urandom_range(0, 31));
        last_reg = AW'($urandom_range(0, 31));
        step(1'($urandom_range(0, 1)), 1'b0, rmode);
      end else begin
        step(1'b0, 1'b0, rmode);
      end
    end
    chk("done_seen", 64'(done_cnt), 1);
    if (exp_done >= 0) chk("done_time", 64'(done_t), 64'(exp_done));
    chk("busy_at_done", 64'(busy_done), 1);
    step(1'b0, 1'b0, 0);
    chk("busy_after_done", 64'(busy), 0);
    chk("done_once", 64'(done_cnt), 1);
    chk("valid_seen", 64'(vseen), 64'(exp_v));
    chk("queue_empty", 64'(q.size()), 0);
    chk("rd_addr_end", 64'(rd_addr), 64'(exp_rd));
    if (rmode == 0 && exp_v) chk("first_valid_t", 64'(fv_t), 2);
  endtask

  task automatic run_dump(input int f,
                          input int l,
                          input int rmode);
    int ed;
    ed = (f > l) ? 1 : 2 * (l - f + 1) + 1;
    push_window(f, l);
    start_dump(f, l, rmode);
    if (f <= l) begin
      step(1'b0, 1'b0, rmode);
      chk("rd_addr_start", 64'(rd_addr), 64'(f));
      chk("valid_after_e0", 64'(out_valid), 0);
    end
    finish_dump(rmode, (rmode == 0) ? ed : -1,
                f <= l, (f > l) ? f : l);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'd1;
    rf[2] = 32'd7;
    rf[3] = 32'd5;
    vt[0] = '{f: 0,  l: 3,  rmode: 0, exp_done: 9};
    vt[1] = '{f: 0,  l: 31, rmode: 1, exp_done: -1};
    vt[2] = '{f: 5,  l: 2,  rmode: 0, exp_done: 1};
    vt[3] = '{f: 31, l: 31, rmode: 0, exp_done: 3};
    vt[4] = '{f: 10, l: 17, rmode: 1, exp_done: -1};
    vt[5] = '{f: 0,  l: 31, rmode: 0, exp_done: 65};

    #1;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        for (int r = 4; r < 32; r++) rf[r] = $urandom;
      end
      run_dump(vt[i].f, vt[i].l, vt[i].rmode);
      if (vt[i].exp_done >= 0) begin
        chk("vec_done_t", 64'(done_t), 64'(vt[i].exp_done));
      end
    end

    push_window(2, 2);
    pw_en = 1'b1;
    pw_t = 3;
    pw_a = 5'd2;
    pw_d = 32'hDEADBEEF;
    start_dump(2, 2, 2);
    repeat (5) step(1'b0, 1'b0, 2);
    chk("hold_wr_valid", 64'(out_valid), 1);
    chk("hold_wr_data", 64'(out_data), 7);
    finish_dump(0, -1, 1'b1, 2);
    run_dump(2, 2, 0);

    q.push_back('{a: 5'd3, d: 32'h12345678});
    pw_en = 1'b1;
    pw_t = 1;
    pw_a = 5'd3;
    pw_d = 32'h12345678;
    start_dump(3, 3, 0);
    finish_dump(0, 3, 1'b1, 3);

    rf[2] = 32'd7;
    rf[3] = 32'd5;
    push_window(0, 2);
    start_dump(0, 3, 0);
    repeat (7) step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    chk("abort_pre_valid", 64'(out_valid), 1);
    chk("abort_pre_addr", 64'(out_addr), 3);
    step(1'b0, 1'b0, 0);
    chk("abort_valid", 64'(out_valid), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    repeat (3) step(1'b0, 1'b0, 0);
    chk("abort_no_done", 64'(done_cnt), 0);
    chk("abort_queue", 64'(q.size()), 0);
    run_dump(0, 3, 0);

    push_window(0, 31);
    start_dump(0, 31, 1);
    for (int k = 0; k < 20; k++) begin
      step(1'($urandom_range(0, 1)), 1'b0, 1);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_reset("mid_reset");
    q.delete();
    held_v = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("reset_no_done", 64'(done_cnt), 0);
    run_dump(0, 5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
